// File: rtl/sb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : sb_ram_slave
// Purpose  : On-chip RAM target on the shared system bus. Decodes an aligned
//            address window, stores 32-bit words under byte enables and
//            replays them as read bursts. Every output is zero whenever the
//            block is not actively driving, because outputs are OR'd onto
//            the bus.
// Ports    : sb_clock_i / sb_reset_i        clock, async active-low reset
//            sb_begin_transaction_i         start; address on data bus
//            sb_end_transaction_i           write close or abort
//            sb_error_i                     error from another agent (abort)
//            sb_address_data_i [31:0]       address at begin / write data
//            sb_byte_enables_i [3:0]        write lanes, sampled at begin
//            sb_burst_size_i   [7:0]        words minus one, sampled at begin
//            sb_read_n_write_i              1=read 0=write, sampled at begin
//            sb_data_valid_i                write word valid
//            sb_address_data_o [31:0]       read data (0 unless valid)
//            sb_data_valid_o                read word valid
//            sb_end_transaction_o           pulse closing a read burst
//            sb_busy_o                      write stall
//            sb_error_o                     pulse on range error
// Revision : 1.0 - initial release
// ============================================================================
module sb_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 2
) (
    input  logic        sb_clock_i,
    input  logic        sb_reset_i,
    input  logic        sb_begin_transaction_i,
    input  logic        sb_end_transaction_i,
    input  logic        sb_error_i,
    input  logic [31:0] sb_address_data_i,
    input  logic [3:0]  sb_byte_enables_i,
    input  logic [7:0]  sb_burst_size_i,
    input  logic        sb_read_n_write_i,
    input  logic        sb_data_valid_i,
    output logic [31:0] sb_address_data_o,
    output logic        sb_data_valid_o,
    output logic        sb_end_transaction_o,
    output logic        sb_busy_o,
    output logic        sb_error_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Wide enough that index + burst_size never wraps.
    localparam int SUM_W = ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8) + 1;
    localparam logic [SUM_W-1:0] MAX_INDEX = SUM_W'(DEPTH - 1);
    // Wait phases last max(WAIT_STATES,1) cycles for reads, WAIT_STATES for writes.
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ERROR    = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_RD_BURST = 3'd3,
        ST_RD_END   = 3'd4,
        ST_WR_WAIT  = 3'd5,
        ST_WR_DATA  = 3'd6
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic [7:0]              size_q;
    logic [3:0]              be_q;
    logic [3:0]              wait_q;
    logic [8:0]              wcnt_q;
    logic                    valid_q;
    logic                    end_q;
    logic                    busy_q;
    logic                    error_q;
    logic [31:0]             rdata_q;
    logic [31:0]             mem_q [DEPTH];

    logic                    hit_d;
    logic [ADDR_WIDTH-1:0]   index_d;
    logic [SUM_W-1:0]        last_d;
    logic                    range_err_d;
    logic                    ext_err_d;
    logic                    abort_d;
    logic                    rd_en_d;
    logic                    wr_en_d;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^sb_address_data_i[1:0];

    assign hit_d       = (sb_address_data_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign index_d     = sb_address_data_i[ADDR_WIDTH+1:2];
    assign last_d      = SUM_W'(index_d) + SUM_W'(sb_burst_size_i);
    assign range_err_d = (last_d > MAX_INDEX);

    // Our own end/error pulses come back through the OR'd bus; mask them so
    // they are not mistaken for an abort from another agent.
    assign ext_err_d = sb_error_i & ~error_q;
    assign abort_d   = (sb_end_transaction_i & ~end_q) | ext_err_d;

    always_comb begin
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        if (!abort_d) begin
            if (state_q == ST_RD_WAIT && wait_q == 4'd0) begin
                rd_en_d = 1'b1;
            end
            if (state_q == ST_RD_BURST && size_q != 8'd0) begin
                rd_en_d = 1'b1;
            end
        end
        // A write word arriving with end_transaction is still committed;
        // words past the burst length are dropped.
        if (state_q == ST_WR_DATA && sb_data_valid_i && !ext_err_d &&
            (wcnt_q <= {1'b0, size_q})) begin
            wr_en_d = 1'b1;
        end
    end

    // RAM array: not reset, contents undefined after reset.
    always_ff @(posedge sb_clock_i) begin
        if (wr_en_d) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[ptr_q][8*i +: 8] <= sb_address_data_i[8*i +: 8];
                end
            end
        end
        if (rd_en_d) begin
            rdata_q <= mem_q[ptr_q];
        end
    end

    always_ff @(posedge sb_clock_i or negedge sb_reset_i) begin
        if (!sb_reset_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            size_q  <= '0;
            be_q    <= '0;
            wait_q  <= '0;
            wcnt_q  <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            end_q   <= 1'b0;
            error_q <= 1'b0;
            if (state_q != ST_IDLE && abort_d) begin
                state_q <= ST_IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sb_begin_transaction_i && hit_d) begin
                            ptr_q  <= index_d;
                            size_q <= sb_burst_size_i;
                            be_q   <= sb_byte_enables_i;
                            wait_q <= WAIT_LOAD;
                            wcnt_q <= '0;
                            if (range_err_d) begin
                                state_q <= ST_ERROR;
                                error_q <= 1'b1;
                            end else if (sb_read_n_write_i) begin
                                state_q <= ST_RD_WAIT;
                            end else if (WAIT_STATES == 0) begin
                                state_q <= ST_WR_DATA;
                            end else begin
                                state_q <= ST_WR_WAIT;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    ST_ERROR: begin
                        state_q <= ST_IDLE;
                    end
                    ST_RD_WAIT: begin
                        // Last wait cycle issues the first synchronous RAM read.
                        if (wait_q == 4'd0) begin
                            valid_q <= 1'b1;
                            ptr_q   <= ptr_q + 1'b1;
                            state_q <= ST_RD_BURST;
                        end else begin
                            wait_q <= wait_q - 4'd1;
                        end
                    end
                    ST_RD_BURST: begin
                        // size_q doubles as the remaining-word counter.
                        if (size_q != 8'd0) begin
                            size_q <= size_q - 8'd1;
                            ptr_q  <= ptr_q + 1'b1;
                        end else begin
                            valid_q <= 1'b0;
                            end_q   <= 1'b1;
                            state_q <= ST_RD_END;
                        end
                    end
                    ST_RD_END: begin
                        state_q <= ST_IDLE;
                    end
                    ST_WR_WAIT: begin
                        if (wait_q == 4'd0) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_WR_DATA;
                        end else begin
                            wait_q <= wait_q - 4'd1;
                        end
                    end
                    ST_WR_DATA: begin
                        if (wr_en_d) begin
                            ptr_q  <= ptr_q + 1'b1;
                            wcnt_q <= wcnt_q + 9'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sb_address_data_o    = valid_q ? rdata_q : 32'h0;
    assign sb_data_valid_o      = valid_q;
    assign sb_end_transaction_o = end_q;
    assign sb_busy_o            = busy_q;
    assign sb_error_o           = error_q;

endmodule
`default_nettype wire

// File: tb/tb_sb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_sb_ram_slave
// Purpose  : Scoreboard bench for sb_ram_slave. Stimulus tasks push the
//            expected bus events (cycle + output value) into a queue; a
//            monitor on the falling edge pops one entry for every cycle in
//            which the slave drives anything and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sb_ram_slave;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        begin_i, tb_end, tb_err, rnw_i, dv_i;
    logic [31:0] ad_i;
    logic [3:0]  be_i;
    logic [7:0]  bs_i;
    logic [31:0] data_o;
    logic        dv_o, end_o, busy_o, err_o;
    logic        end_bus, err_bus;

    // The slave's own pulses return through the OR'd bus.
    assign end_bus = tb_end | end_o;
    assign err_bus = tb_err | err_o;

    sb_ram_slave #(
        .BASE_ADDR   (32'h0000_0000),
        .ADDR_WIDTH  (10),
        .WAIT_STATES (WS)
    ) dut (
        .sb_clock_i             (clk),
        .sb_reset_i             (rst_n),
        .sb_begin_transaction_i (begin_i),
        .sb_end_transaction_i   (end_bus),
        .sb_error_i             (err_bus),
        .sb_address_data_i      (ad_i),
        .sb_byte_enables_i      (be_i),
        .sb_burst_size_i        (bs_i),
        .sb_read_n_write_i      (rnw_i),
        .sb_data_valid_i        (dv_i),
        .sb_address_data_o      (data_o),
        .sb_data_valid_o        (dv_o),
        .sb_end_transaction_o   (end_o),
        .sb_busy_o              (busy_o),
        .sb_error_o             (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        logic [35:0] val;   // {data_valid, end, busy, error, data}
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] wbuf [8];
    logic [31:0] ebuf [8];

    function automatic void expect_out(input int c, input logic v, input logic e,
                                       input logic b, input logic r, input logic [31:0] d);
        exp_t x;
        x.cyc = c;
        x.val = {v, e, b, r, d};
        exp_q.push_back(x);
    endfunction

    // Monitor: every cycle the slave drives anything must match the head of the queue.
    always @(negedge clk) begin
        logic [35:0] act;
        exp_t        e;
        act = {dv_o, end_o, busy_o, err_o, data_o};
        if (act != 36'h0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output cycle %0d got %h required idle bus", cyc, act);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.val != act) begin
                    n_fail++;
                    $display("FAIL bus_event got cycle %0d value %h required cycle %0d value %h",
                             cyc, act, e.cyc, e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if ({dv_o, end_o, busy_o, err_o, data_o} != 36'h0) begin
            n_fail++;
            $display("FAIL %s got %h required 0", name, {dv_o, end_o, busy_o, err_o, data_o});
        end
    endtask

    // kind: 0 = hit, 1 = range error, 2 = miss. Data words come from wbuf;
    // the last word is presented together with end_transaction.
    task automatic do_write(input logic [31:0] addr, input logic [3:0] be,
                            input int n, input int kind);
        int b;
        b       = cyc;
        begin_i = 1'b1;
        ad_i    = addr;
        be_i    = be;
        bs_i    = 8'(n - 1);
        rnw_i   = 1'b0;
        if (kind == 0) begin
            for (int k = 1; k <= WS; k++) expect_out(b + k, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        end else if (kind == 1) begin
            expect_out(b + 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        end
        tick();
        begin_i = 1'b0;
        ad_i    = 32'h0;
        be_i    = 4'h0;
        bs_i    = 8'h0;
        while (cyc < b + WS + 1) tick();
        for (int k = 0; k < n; k++) begin
            dv_i   = 1'b1;
            ad_i   = wbuf[k];
            tb_end = (k == n - 1);
            tick();
        end
        dv_i   = 1'b0;
        ad_i   = 32'h0;
        tb_end = 1'b0;
        tick();
    endtask

    // Expected read words come from ebuf. abort_after >= 0 drives an external
    // end_transaction during the cycle the last wanted word is on the bus.
    task automatic do_read(input logic [31:0] addr, input int size,
                           input int kind, input int abort_after);
        int b;
        int nw;
        b       = cyc;
        begin_i = 1'b1;
        ad_i    = addr;
        bs_i    = 8'(size);
        rnw_i   = 1'b1;
        be_i    = 4'h0;
        if (kind == 1) begin
            expect_out(b + 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        end else if (kind == 0) begin
            nw = (abort_after >= 0) ? abort_after : size + 1;
            for (int k = 0; k < nw; k++)
                expect_out(b + WS + 1 + k, 1'b1, 1'b0, 1'b0, 1'b0, ebuf[k]);
            if (abort_after < 0)
                expect_out(b + WS + 2 + size, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        end
        tick();
        begin_i = 1'b0;
        ad_i    = 32'h0;
        bs_i    = 8'h0;
        rnw_i   = 1'b0;
        if (kind == 0 && abort_after >= 0) begin
            while (cyc < b + WS + abort_after) tick();
            tb_end = 1'b1;
            tick();
            tb_end = 1'b0;
        end
        while (cyc < b + WS + size + 5) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst_n   = 1'b0;
        begin_i = 1'b0;
        tb_end  = 1'b0;
        tb_err  = 1'b0;
        rnw_i   = 1'b0;
        dv_i    = 1'b0;
        ad_i    = 32'h0;
        be_i    = 4'h0;
        bs_i    = 8'h0;
        #1;
        check_zero("reset_state");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single word write then read back.
        wbuf[0] = 32'hDEADBEEF;
        do_write(32'h0000_0100, 4'hF, 1, 0);
        ebuf[0] = 32'hDEADBEEF;
        do_read(32'h0000_0100, 0, 0, -1);

        // Burst write 1..4 at 0, a miss at 0x1000 (outside the 4 KiB window)
        // must not touch index 0, then burst read back.
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
        do_write(32'h0000_0000, 4'hF, 4, 0);
        wbuf[0] = 32'hFFFF_FFFF;
        do_write(32'h0000_1000, 4'hF, 1, 2);
        ebuf[0] = 32'd1; ebuf[1] = 32'd2; ebuf[2] = 32'd3; ebuf[3] = 32'd4;
        do_read(32'h0000_0000, 3, 0, -1);

        // Byte enables 0101 over 0x11223344.
        wbuf[0] = 32'h1122_3344;
        do_write(32'h0000_0200, 4'hF, 1, 0);
        wbuf[0] = 32'hAABB_CCDD;
        do_write(32'h0000_0200, 4'b0101, 1, 0);
        ebuf[0] = 32'h11BB_33DD;
        do_read(32'h0000_0200, 0, 0, -1);

        // Top of memory: last word is legal, one past it is a range error.
        wbuf[0] = 32'hCAFE_F00D;
        do_write(32'h0000_0FFC, 4'hF, 1, 0);
        wbuf[0] = 32'h0BAD_0BAD; wbuf[1] = 32'h0BAD_0BAD;
        do_write(32'h0000_0FFC, 4'hF, 2, 1);
        do_read(32'h0000_0FFC, 1, 1, -1);
        ebuf[0] = 32'hCAFE_F00D;
        do_read(32'h0000_0FFE, 0, 0, -1);   // addr[1:0] ignored

        // Miss: no response at all.
        do_read(32'h8000_0000, 0, 2, -1);

        // Abort after 3 words of an 8-word read, then a normal read.
        for (int k = 0; k < 8; k++) wbuf[k] = 32'h10 + 32'(k);
        do_write(32'h0000_0040, 4'hF, 8, 0);
        ebuf[0] = 32'h10; ebuf[1] = 32'h11; ebuf[2] = 32'h12;
        do_read(32'h0000_0040, 7, 0, 3);
        ebuf[0] = 32'h11; ebuf[1] = 32'h12;
        do_read(32'h0000_0044, 1, 0, -1);

        // Reset asserted mid-burst: outputs drop at once.
        b       = cyc;
        begin_i = 1'b1;
        ad_i    = 32'h0000_0040;
        bs_i    = 8'd7;
        rnw_i   = 1'b1;
        expect_out(b + WS + 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
        tick();
        begin_i = 1'b0;
        ad_i    = 32'h0;
        bs_i    = 8'h0;
        rnw_i   = 1'b0;
        while (cyc < b + WS + 2) tick();
        rst_n = 1'b0;
        #1;
        check_zero("async_reset_mid_burst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        ebuf[0] = 32'h16; ebuf[1] = 32'h17;
        do_read(32'h0000_0058, 1, 0, -1);

        repeat (4) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events got %0d outstanding required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
